// File: rtl/seq_detect_ctrl.sv
// Serial pattern detector that counts matches over a window of valid input bits.
// Overlapping or non-overlapping counting is selected by the latched configuration.
module seq_detect_ctrl #(
    parameter int PW = 8,
    parameter int CW = 8,
    parameter int WW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [PW-1:0] cfg_pattern,
    input  logic [3:0]    cfg_len,
    input  logic          cfg_overlap,
    input  logic          start,
    input  logic [WW-1:0] win_len,
    input  logic          din_valid,
    input  logic          din,
    output logic          busy,
    output logic          match,
    output logic [CW-1:0] match_count,
    output logic          done
);

    localparam int FW = $clog2(PW + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]    state;
    logic [PW-1:0] pat;
    logic [3:0]    len;
    logic          ovl;
    logic [PW-1:0] hist;
    logic [FW-1:0] fill;
    logic [WW-1:0] bitcnt;
    logic [WW-1:0] winlen;

    logic [PW-1:0] hist_nxt;
    logic [FW-1:0] fill_inc;
    logic [WW-1:0] bit_nxt;
    logic          hit;
    logic          last;

    // Out-of-range lengths are folded into 1..PW when latched.
    function automatic logic [3:0] clamp_len(input logic [3:0] l);
        if (l == 4'd0)
            return 4'd1;
        else if (int'(l) > PW)
            return 4'(PW);
        else
            return l;
    endfunction

    function automatic logic [PW-1:0] len_mask(input logic [3:0] l);
        logic [PW-1:0] m;
        for (int i = 0; i < PW; i++)
            m[i] = (i < int'(l));
        return m;
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        if (&c)
            return c;
        else
            return c + CW'(1);
    endfunction

    always_comb begin
        hist_nxt = {hist[PW-2:0], din};
        fill_inc = (int'(fill) >= PW) ? fill : fill + FW'(1);
        bit_nxt  = bitcnt + WW'(1);
        hit      = (int'(fill_inc) >= int'(len)) &&
                   (((hist_nxt ^ pat) & len_mask(len)) == '0);
        last     = (bit_nxt == winlen);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pat         <= '0;
            len         <= 4'(PW);
            ovl         <= 1'b1;
            hist        <= '0;
            fill        <= '0;
            bitcnt      <= '0;
            winlen      <= '0;
            match       <= 1'b0;
            match_count <= '0;
        end else begin
            match <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_we) begin
                        pat <= cfg_pattern;
                        len <= clamp_len(cfg_len);
                        ovl <= cfg_overlap;
                    end
                    if (start) begin
                        winlen      <= win_len;
                        hist        <= '0;
                        fill        <= '0;
                        bitcnt      <= '0;
                        match_count <= '0;
                        state       <= (win_len == '0) ? FIN : RUN;
                    end
                end
                RUN: begin
                    if (din_valid) begin
                        hist   <= hist_nxt;
                        bitcnt <= bit_nxt;
                        if (hit) begin
                            match       <= 1'b1;
                            match_count <= sat_inc(match_count);
                            // Non-overlapping mode demands a full set of fresh bits.
                            fill        <= ovl ? fill_inc : '0;
                        end else begin
                            fill <= fill_inc;
                        end
                        if (last)
                            state <= FIN;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == FIN);

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl; a second instance with CW=2 covers counter saturation.
module tb_seq_detect_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_we = 1'b0;
    logic [7:0]  cfg_pattern = '0;
    logic [3:0]  cfg_len = '0;
    logic        cfg_overlap = 1'b0;
    logic        start = 1'b0;
    logic [15:0] win_len = '0;
    logic        din_valid = 1'b0;
    logic        din = 1'b0;

    logic        busy, match, done;
    logic [7:0]  match_count;
    logic        busy2, match2, done2;
    logic [1:0]  match_count2;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    seq_detect_ctrl #(.PW(8), .CW(8), .WW(16)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .start(start),
        .win_len(win_len), .din_valid(din_valid), .din(din),
        .busy(busy), .match(match), .match_count(match_count), .done(done)
    );

    seq_detect_ctrl #(.PW(8), .CW(2), .WW(16)) dut2 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .start(start),
        .win_len(win_len), .din_valid(din_valid), .din(din),
        .busy(busy2), .match(match2), .match_count(match_count2), .done(done2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input logic [7:0] p, input logic [3:0] l, input logic ov);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = ov;
        cfg_we      = 1'b1;
        tick();
        cfg_we      = 1'b0;
    endtask

    task automatic begin_win(input logic [15:0] n);
        win_len = n;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // bits[0] is sent first; expm[i] is the expected match after bit i.
    task automatic run_bits(input string tag, input int n, input logic [31:0] bits,
                            input logic [31:0] expm, input bit fin, input int expc);
        for (int i = 0; i < n; i++) begin
            din       = bits[i];
            din_valid = 1'b1;
            tick();
            din_valid = 1'b0;
            check({tag, "_match"}, match, expm[i]);
            check({tag, "_done"}, done, (fin && i == n - 1));
        end
        if (fin) begin
            check({tag, "_busy_fin"}, busy, 0);
            check({tag, "_count"}, match_count, expc);
            tick();
            check({tag, "_done_clr"}, done, 0);
            check({tag, "_count_hold"}, match_count, expc);
        end else begin
            check({tag, "_busy_run"}, busy, 1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_match", match, 0);
        check("rst_count", match_count, 0);

        // Overlapping 1010 in 1010101
        configure(8'b0000_1010, 4'd4, 1'b1);
        begin_win(16'd7);
        check("ov_busy", busy, 1);
        run_bits("ov", 7, 32'b1010101, 32'h28, 1'b1, 2);

        // Non-overlapping
        configure(8'b0000_1010, 4'd4, 1'b0);
        begin_win(16'd7);
        run_bits("nov", 7, 32'b1010101, 32'h08, 1'b1, 1);

        // Empty window
        begin_win(16'd0);
        check("w0_busy", busy, 0);
        check("w0_done", done, 1);
        check("w0_count", match_count, 0);
        tick();
        check("w0_done_clr", done, 0);
        check("w0_busy_after", busy, 0);

        // cfg_we and start mid-window are ignored; an invalid-cycle gap changes nothing
        configure(8'b0000_1010, 4'd4, 1'b1);
        begin_win(16'd7);
        run_bits("ign_a", 2, 32'b01, 32'h0, 1'b0, 0);
        cfg_pattern = 8'b0000_0111;
        cfg_len     = 4'd3;
        cfg_overlap = 1'b0;
        cfg_we      = 1'b1;
        win_len     = 16'd2;
        start       = 1'b1;
        din         = 1'b1;
        tick();
        cfg_we = 1'b0;
        start  = 1'b0;
        check("ign_gap_match", match, 0);
        check("ign_gap_busy", busy, 1);
        run_bits("ign_b", 5, 32'b10101, 32'b01010, 1'b1, 2);

        // Saturation: CW=2 instance holds at 3
        configure(8'b0000_0001, 4'd1, 1'b1);
        begin_win(16'd5);
        run_bits("sat", 5, 32'b11111, 32'b11111, 1'b1, 5);
        check("sat_count2", match_count2, 3);
        check("sat_busy2", busy2, 0);

        // Length 0 clamps to 1
        configure(8'b0000_0001, 4'd0, 1'b1);
        begin_win(16'd3);
        run_bits("len0", 3, 32'b101, 32'b101, 1'b1, 2);

        // Reset mid-window aborts with no done
        configure(8'b0000_0101, 4'd3, 1'b1);
        begin_win(16'd7);
        run_bits("rsta", 3, 32'b101, 32'b100, 1'b0, 0);
        check("rsta_count_pre", match_count, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rsta_busy", busy, 0);
        check("rsta_count", match_count, 0);
        check("rsta_done", done, 0);
        tick();
        check("rsta_done_late", done, 0);

        // Fresh start with reset configuration: pattern 0, length 8, overlap on
        begin_win(16'd9);
        run_bits("rcfg", 9, 32'b0, 32'h180, 1'b1, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
